// File: rtl/adc_sample_conditioner_if.sv
// Bundles the ADC beat input, the control strobes and the outgoing sample
// stream of the ADC sample conditioner. The conditioner uses the slave
// modport; whatever feeds it and drains it uses the master modport.
interface adc_sample_conditioner_if #(
    parameter int OUT_W           = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
);
    logic                       adc_response_valid;
    logic [4:0]                 adc_response_channel;
    logic [11:0]                adc_response_data;
    logic                       enable;
    logic                       sample_valid;
    logic [OUT_W-1:0]           sample_data;
    logic                       sample_ready;
    logic [FIFO_DEPTH_LOG2:0]   fifo_level;
    logic                       overflow;
    logic                       overflow_clr;

    modport master (
        output adc_response_valid,
        output adc_response_channel,
        output adc_response_data,
        output enable,
        output sample_ready,
        output overflow_clr,
        input  sample_valid,
        input  sample_data,
        input  fifo_level,
        input  overflow
    );

    modport slave (
        input  adc_response_valid,
        input  adc_response_channel,
        input  adc_response_data,
        input  enable,
        input  sample_ready,
        input  overflow_clr,
        output sample_valid,
        output sample_data,
        output fifo_level,
        output overflow
    );
endinterface

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: picks one channel out of the ADC response stream,
// converts offset-binary codes to two's complement, block-averages
// 2**DECIM_LOG2 samples (floor rounding) and queues the left-justified
// results in a small FIFO drained with a valid/ready handshake.
module adc_sample_conditioner #(
    parameter int CHANNEL         = 1,
    parameter int DECIM_LOG2      = 2,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int OUT_W           = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    adc_sample_conditioner_if.slave bus
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int ACC_W = 12 + DECIM_LOG2;
    // A zero-width counter is not legal, so D=0 keeps a 1-bit counter that
    // never leaves zero (every beat is then the last beat of its block).
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PTR_W = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;
    localparam logic [CNT_W-1:0]           CNT_LAST   = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    // Averaging datapath
    logic                     beat_accept;
    logic signed [11:0]       beat_sample;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shift;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     block_done;
    logic signed [11:0]       block_result;
    logic [OUT_W-1:0]         push_word;

    // FIFO
    logic [OUT_W-1:0]         mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [FIFO_DEPTH_LOG2:0] level_reg;
    logic [FIFO_DEPTH_LOG2:0] level_next;
    logic                     overflow_reg;
    logic                     push_req;
    logic                     push_ok;
    logic                     pop;
    logic                     fifo_full;
    logic                     overflow_set;

    assign beat_accept  = bus.adc_response_valid && bus.enable &&
                          (bus.adc_response_channel == 5'(CHANNEL));
    // Flipping the MSB of an offset-binary code gives code - 2048.
    assign beat_sample  = {~bus.adc_response_data[11], bus.adc_response_data[10:0]};
    assign acc_sum      = acc_reg + ACC_W'(beat_sample);
    assign acc_shift    = acc_sum >>> DECIM_LOG2;
    assign block_result = acc_shift[11:0];
    assign block_done   = (cnt_reg == CNT_LAST);
    assign push_word    = OUT_W'($unsigned(block_result)) << (OUT_W - 12);

    assign push_req     = beat_accept && block_done;
    assign fifo_full    = (level_reg == LEVEL_FULL);
    assign pop          = bus.sample_valid && bus.sample_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    // Accumulate accepted beats; a disabled cycle throws away the partial block
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (!bus.enable) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (beat_accept) begin
            if (block_done) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_sum;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (bus.overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Sample storage; contents need no reset because level gates every read
    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    assign bus.sample_valid = (level_reg != '0);
    assign bus.sample_data  = (level_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign bus.fifo_level   = level_reg;
    assign bus.overflow     = overflow_reg;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner with a queue scoreboard: the
// expected output words are queued as stimulus is issued and popped by a
// monitor whenever the DUT hands a sample over.
module tb_adc_sample_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    adc_sample_conditioner_if #(.OUT_W(16), .FIFO_DEPTH_LOG2(2)) bus ();

    adc_sample_conditioner #(
        .CHANNEL(1),
        .DECIM_LOG2(2),
        .FIFO_DEPTH_LOG2(2),
        .OUT_W(16)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every handshake seen on the falling edge pops one expectation
    always @(negedge clk) begin
        logic [15:0] exp_word;
        if (!rst && bus.sample_valid && bus.sample_ready) begin
            exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            total++;
            assert (bus.sample_data === exp_word) else begin
                bad++;
                $error("FAIL pop_data observed=%h expected=%h", bus.sample_data, exp_word);
            end
            $display("pop sample=%h expected=%h", bus.sample_data, exp_word);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] d);
        bus.adc_response_valid   = 1'b1;
        bus.adc_response_channel = ch;
        bus.adc_response_data    = d;
        sync();
        bus.adc_response_valid   = 1'b0;
    endtask

    task automatic block4(input logic [11:0] d);
        for (int i = 0; i < 4; i++) send(5'd1, d);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        sync();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_valid"},    32'(bus.sample_valid), 32'd0);
        chk({tag, "_data"},     32'(bus.sample_data),  32'd0);
        chk({tag, "_level"},    32'(bus.fifo_level),   32'd0);
        chk({tag, "_overflow"}, 32'(bus.overflow),     32'd0);
        sync();
    endtask

    initial begin
        bus.adc_response_valid   = 1'b0;
        bus.adc_response_channel = 5'd0;
        bus.adc_response_data    = 12'd0;
        bus.enable               = 1'b1;
        bus.sample_ready         = 1'b0;
        bus.overflow_clr         = 1'b0;

        // Reset state
        repeat (3) sync();
        chk_idle("reset");
        rst = 1'b0;
        sync();
        bus.sample_ready = 1'b1;

        // Midscale, full-scale positive and negative blocks
        exp_q.push_back(16'h0000); block4(12'd2048);
        exp_q.push_back(16'h7FF0); block4(12'd4095);
        exp_q.push_back(16'h8000); block4(12'd0);
        wait_drain();

        // Rounding: positive average and floor of a negative sum
        exp_q.push_back(16'h0020);
        send(5'd1, 12'd2049); send(5'd1, 12'd2050); send(5'd1, 12'd2051); send(5'd1, 12'd2052);
        exp_q.push_back(16'hFFE0);
        send(5'd1, 12'd2047); send(5'd1, 12'd2047); send(5'd1, 12'd2047); send(5'd1, 12'd2046);
        wait_drain();

        // Foreign-channel beats interleaved must be ignored
        exp_q.push_back(16'h0010);
        send(5'd2, 12'd0); send(5'd1, 12'd2049); send(5'd2, 12'd0); send(5'd1, 12'd2049);
        send(5'd2, 12'd0); send(5'd1, 12'd2049); send(5'd1, 12'd2049); send(5'd2, 12'd0);
        send(5'd2, 12'd0);
        wait_drain();
        repeat (3) sync();
        @(negedge clk);
        chk("ch_filter_level", 32'(bus.fifo_level), 32'd0);
        sync();

        // Overflow: five blocks into a four-deep FIFO with no consumer
        bus.sample_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(16'(k << 4));
            block4(12'(2048 + k));
        end
        @(negedge clk);
        chk("ovf_level",    32'(bus.fifo_level),  32'd4);
        chk("ovf_flag",     32'(bus.overflow),    32'd1);
        chk("ovf_head",     32'(bus.sample_data), 32'h0010);
        sync();
        bus.sample_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("ovf_drained_level", 32'(bus.fifo_level), 32'd0);
        chk("ovf_sticky",        32'(bus.overflow),   32'd1);
        sync();
        bus.overflow_clr = 1'b1;
        sync();
        bus.overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        sync();

        // Full FIFO with a pop on the push edge: no loss, no overflow
        bus.sample_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(16'(k << 4));
            block4(12'(2048 + k));
        end
        exp_q.push_back(16'h0050);
        @(negedge clk);
        chk("full_level", 32'(bus.fifo_level), 32'd4);
        sync();
        send(5'd1, 12'd2053); send(5'd1, 12'd2053); send(5'd1, 12'd2053);
        bus.sample_ready = 1'b1;
        send(5'd1, 12'd2053);
        bus.sample_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_level",    32'(bus.fifo_level),  32'd4);
        chk("pushpop_overflow", 32'(bus.overflow),    32'd0);
        chk("pushpop_head",     32'(bus.sample_data), 32'h0020);
        sync();
        bus.sample_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a block wipes everything
        bus.sample_ready = 1'b0;
        block4(12'd2049);
        @(negedge clk);
        chk("prereset_level", 32'(bus.fifo_level), 32'd1);
        sync();
        send(5'd1, 12'd2049); send(5'd1, 12'd2049);
        rst = 1'b1;
        chk_idle("midreset");
        rst = 1'b0;
        sync();
        bus.sample_ready = 1'b1;
        send(5'd1, 12'd2050); send(5'd1, 12'd2050); send(5'd1, 12'd2050);
        @(negedge clk);
        chk("postreset_no_early", 32'(bus.sample_valid), 32'd0);
        sync();
        exp_q.push_back(16'h0020);
        send(5'd1, 12'd2050);
        wait_drain();

        // One disabled cycle drops the partial block but keeps queued results
        bus.sample_ready = 1'b0;
        exp_q.push_back(16'h0030);
        exp_q.push_back(16'h0020);
        block4(12'd2051);
        send(5'd1, 12'd2049); send(5'd1, 12'd2049);
        bus.enable = 1'b0;
        sync();
        bus.enable = 1'b1;
        @(negedge clk);
        chk("disable_kept_level", 32'(bus.fifo_level), 32'd1);
        sync();
        send(5'd1, 12'd2050); send(5'd1, 12'd2050); send(5'd1, 12'd2050);
        @(negedge clk);
        chk("disable_no_early", 32'(bus.fifo_level), 32'd1);
        sync();
        send(5'd1, 12'd2050);
        @(negedge clk);
        chk("disable_level2", 32'(bus.fifo_level), 32'd2);
        sync();
        bus.sample_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
